fdiv_iter: RTL and testbench

- Single-precision floating-point divider, y = x1 / x2; the iterative counterpart to the team's pipelined multiplier in the FPU.
- Radix-2 restoring mantissa division, N quotient bits per cycle, followed by one normalize/round cycle.
- Valid/ready handshake on both sides; one operation in flight.
- Operand and result conventions match the multiplier: zero/denormal inputs are flushed to zero, round-to-nearest-even, no NaN handling.

---
 rtl/fdiv_iter.sv | 145 ++++++++++++++
 tb/tb_fdiv_iter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter.sv
// Iterative single-precision divider: radix-2 restoring mantissa division, then one normalize/round cycle.
// Optional FDIV_OVF_SAT_EN: exponent overflow saturates to infinity instead of wrapping.
module fdiv_iter #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned QW    = 27;
  localparam int unsigned ITER  = QW / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned MW    = 24;
  localparam int unsigned RW    = 25;
  localparam int unsigned EW    = 10;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t state, state_nxt;
  logic        in_ready_nxt, out_valid_nxt;
  logic [31:0] y_nxt;

  logic          sign_q, z1_q, z2_q;
  logic [7:0]    e1_q, e2_q;
  logic [MW-1:0] m2_q;
  logic [RW-1:0] rem_q, rem_step;
  logic [QW-1:0] q_q, q_step;
  logic [CNT_W-1:0] cnt_q;

  // BITS_PER_CYCLE restoring steps per clock
  always_comb begin
    rem_step = rem_q;
    q_step   = q_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_step >= {1'b0, m2_q}) begin
        q_step   = {q_step[QW-2:0], 1'b1};
        rem_step = rem_step - {1'b0, m2_q};
      end else begin
        q_step   = {q_step[QW-2:0], 1'b0};
      end
      rem_step = {rem_step[RW-2:0], 1'b0};
    end
  end

  logic          norm, g, r, st, rnd_up, e_le0;
  logic [22:0]   mant_pre;
  logic [MW-1:0] mant_sum;
  logic [EW-1:0] e_pre, e_fin;
  logic [31:0]   res;
`ifdef FDIV_OVF_SAT_EN
  logic          e_ovf;
`endif

  // Normalize, round to nearest even, and select special-case results
  always_comb begin
    norm     = q_q[26];
    mant_pre = norm ? q_q[25:3] : q_q[24:2];
    g        = norm ? q_q[2] : q_q[1];
    r        = norm ? q_q[1] : q_q[0];
    st       = (norm & q_q[0]) | (|rem_q);
    e_pre    = EW'(e1_q) - EW'(e2_q) + (norm ? EW'(127) : EW'(126));
    rnd_up   = g & (r | st | mant_pre[0]);
    mant_sum = {1'b0, mant_pre} + MW'(rnd_up);
    e_fin    = mant_sum[23] ? e_pre + EW'(1) : e_pre;
    e_le0    = e_fin[EW-1] | (e_fin == '0);
`ifdef FDIV_OVF_SAT_EN
    e_ovf    = !e_fin[EW-1] && (e_fin >= EW'(255));
`endif
    if (z2_q)       res = {sign_q, 8'hFF, 23'h0};
    else if (z1_q)  res = {sign_q, 31'h0};
    else if (e_le0) res = {sign_q, 31'h0};
`ifdef FDIV_OVF_SAT_EN
    else if (e_ovf) res = {sign_q, 8'hFF, 23'h0};
`endif
    else            res = {sign_q, e_fin[7:0], mant_sum[22:0]};
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    case (state)
      IDLE:  if (in_valid) state_nxt = CALC;
      CALC:  if (cnt_q == CNT_W'(ITER - 1)) state_nxt = ROUND;
      ROUND: begin
        state_nxt = DONE;
        y_nxt     = res;
      end
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      y         <= y_nxt;
    end
  end

  // Operand capture on accept; iteration state advances only in CALC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign_q <= 1'b0;
      z1_q   <= 1'b0;
      z2_q   <= 1'b0;
      e1_q   <= '0;
      e2_q   <= '0;
      m2_q   <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
    end else if (state == IDLE && in_valid) begin
      sign_q <= x1[31] ^ x2[31];
      z1_q   <= (x1[30:23] == 8'h00);
      z2_q   <= (x2[30:23] == 8'h00);
      e1_q   <= x1[30:23];
      e2_q   <= x2[30:23];
      m2_q   <= {1'b1, x2[22:0]};
      rem_q  <= {2'b01, x1[22:0]};
      q_q    <= '0;
      cnt_q  <= '0;
    end else if (state == CALC) begin
      rem_q  <= rem_step;
      q_q    <= q_step;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// Scoreboard bench for fdiv_iter: three instances (1, 3, 9 bits/cycle) checked for result and latency.
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] x1 = '0, x2 = '0;
  logic [2:0]  in_valid = '0;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y_o [3];

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  int acc_edge [3];
  bit shown [3];
  logic [31:0] last_exp [3];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  fdiv_iter #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .y(y_o[0]), .out_valid(out_valid[0]), .out_ready(out_ready));
  fdiv_iter #(.BITS_PER_CYCLE(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .y(y_o[1]), .out_valid(out_valid[1]), .out_ready(out_ready));
  fdiv_iter #(.BITS_PER_CYCLE(9)) u_dut9 (
    .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .y(y_o[2]), .out_valid(out_valid[2]), .out_ready(out_ready));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic int lat_exp(input int k);
    case (k)
      0: return 28;
      1: return 10;
      default: return 4;
    endcase
  endfunction

  task automatic pop(input int k, output logic [31:0] e, output bit ok);
    ok = 1'b1;
    e  = '0;
    case (k)
      0: if (q0.size() != 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() != 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() != 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Monitor: compares each newly presented result against the scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      if (rstn && in_valid[k] && in_ready[k]) acc_edge[k] = edge_cnt + 1;
      if (!out_valid[k]) shown[k] = 1'b0;
      if (rstn && out_valid[k] && !shown[k]) begin
        shown[k] = 1'b1;
        pop(k, e, ok);
        if (!ok) begin
          n_checks++;
          $display("FAIL unexpected_out dut%0d: got %h expected none", k, y_o[k]);
        end else begin
          last_exp[k] = e;
          check($sformatf("y dut%0d", k), y_o[k], e);
          check($sformatf("latency dut%0d", k), 32'(edge_cnt - acc_edge[k]), 32'(lat_exp(k)));
          check($sformatf("in_ready_busy dut%0d", k), 32'(in_ready[k]), 32'd0);
        end
      end
      if (rstn && out_valid[k] && out_ready && shown[k])
        check($sformatf("y_at_consume dut%0d", k), y_o[k], last_exp[k]);
    end
  end

  task automatic issue(input logic [2:0] mask, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    logic [2:0] pend;
    int n = 0;
    @(posedge clk); #1;
    x1 = a;
    x2 = b;
    if (mask[0]) q0.push_back(e);
    if (mask[1]) q1.push_back(e);
    if (mask[2]) q2.push_back(e);
    in_valid = mask;
    while (in_valid != 0 && n < 200) begin
      @(negedge clk);
      pend = in_valid & in_ready;
      @(posedge clk); #1;
      in_valid = in_valid & ~pend;
      n++;
    end
    if (in_valid != 0) begin
      timeout("accept");
      in_valid = '0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size() != 0 || out_valid != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_y dut%0d", k), y_o[k], 32'h0);
      check($sformatf("reset_out_valid dut%0d", k), 32'(out_valid[k]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'h7);

    // Basic quotients on all three widths; operands scrambled after accept
    issue(3'b111, 32'h40C00000, 32'h40000000, 32'h40400000);
    x1 = 32'hDEADBEEF;
    x2 = 32'h12345678;
    drain();
    issue(3'b111, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    drain();
    issue(3'b111, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    drain();
    issue(3'b111, 32'hC0C00000, 32'h40000000, 32'hC0400000);
    drain();
    // Special operands and exponent limits
    issue(3'b111, 32'h3F800000, 32'h00000000, 32'h7F800000);
    drain();
    issue(3'b001, 32'h00000000, 32'h00000000, 32'h7F800000);
    drain();
    issue(3'b001, 32'h80000000, 32'h40000000, 32'h80000000);
    drain();
    issue(3'b001, 32'h00800000, 32'h40000000, 32'h00000000);
    drain();
`ifdef FDIV_OVF_SAT_EN
    issue(3'b111, 32'h7F000000, 32'h00800000, 32'h7F800000);
`else
    issue(3'b111, 32'h7F000000, 32'h00800000, 32'h3E000000);
`endif
    drain();

    // Backpressure: result held, input blocked, queued operand accepted after release
    out_ready = 1'b0;
    issue(3'b001, 32'h40C00000, 32'h40000000, 32'h40400000);
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("bp_wait_valid");
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        @(posedge clk); #1;
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        q0.push_back(32'h3EAAAAAB);
        in_valid[0] = 1'b1;
      end
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
      check("bp_y", y_o[0], 32'h40400000);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    drain();

    // Reset mid-calculation aborts silently
    issue(3'b001, 32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (9) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    q0.delete();
    check("abort_out_valid", 32'(out_valid[0]), 32'd0);
    check("abort_y", y_o[0], 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("in_ready_after_abort", 32'(in_ready), 32'h7);
    issue(3'b001, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
